tone_cmd_sequencer: RTL and testbench
=====================================

Name: tone_cmd_sequencer

Overview:
Sequences the tone-detector front end (HearFreq) and turns its decoded `command` into timed motor actions for the rover. It gates the detector's listening window through `hear_en`. A tone must be present for a confirmation period before it is accepted. The accepted command drives one motor output for a fixed run time, then a cooldown follows so motor noise cannot re-trigger the detector. It sits between HearFreq and the motor drivers.

Parameters:
- CONFIRM_CYCLES, 10_000_000: consecutive matching samples needed to accept a command (100 ms at 100 MHz); must be >= 1.
- RUN_CYCLES, 100_000_000: clocks the motor output stays asserted (1 s); must be >= 1.
- COOLDOWN_CYCLES, 20_000_000: clocks with detector and motors off after a run; must be >= 1.
- CNT_W, 32: width of the internal timer; must hold the largest of the three cycle parameters.

Ports:
- clk, input, 1: system clock (100 MHz).
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: master run enable; low forces IDLE.
- command, input, 3: detector output; 001 = 500 Hz, 010 = 1 kHz, 100 = 1.5 kHz, 000 = none. Any other value is invalid and treated as none.
- hear_en, output, 1: drives the detector enable.
- motor_fwd, output, 1: forward drive, for command 001.
- motor_rev, output, 1: reverse drive, for command 010.
- motor_turn, output, 1: turn drive, for command 100.
- active_cmd, output, 3: the accepted command, held from EXECUTE entry until the next acceptance.
- busy, output, 1: high in EXECUTE or COOLDOWN.
- cmd_done, output, 1: one-cycle pulse when a run completes normally.
- aborted, output, 1: one-cycle pulse when `enable` falls during CONFIRM or EXECUTE.
- cmd_count, output, 8: count of completed runs; wraps 255 -> 0.

Behaviour:
- All outputs are registers and update on the same edge as the state change.
- Reset, asynchronous: state = IDLE; all outputs = 0; timer = 0; candidate = 000.
- States: IDLE, LISTEN, CONFIRM, EXECUTE, COOLDOWN.
- IDLE: `hear_en` = 0.
  - `enable` = 1 -> LISTEN, with `hear_en` = 1 on that edge.
- LISTEN: `hear_en` = 1.
  - Valid one-hot `command` sampled -> candidate <= `command`, timer <= 1, go to CONFIRM.
  - If CONFIRM_CYCLES = 1, go directly to EXECUTE instead.
- CONFIRM: `hear_en` = 1.
  - `command` == candidate -> timer increments.
  - Timer would reach CONFIRM_CYCLES -> EXECUTE, `active_cmd` <= candidate, the selected motor output goes to 1, `hear_en` <= 0, timer <= 0.
  - `command` != candidate, including a different valid code -> LISTEN, timer cleared. The new code is captured on the following edge at the earliest.
  - Net effect: a command held for exactly CONFIRM_CYCLES samples is accepted, and the motor rises on the edge of the last sample.
- EXECUTE:
  - Exactly one motor output is high, for exactly RUN_CYCLES clocks.
  - On the final clock: -> COOLDOWN, motor outputs 0, `cmd_done` = 1 for one cycle, `cmd_count` increments.
- COOLDOWN:
  - `hear_en` = 0 and motors = 0 for exactly COOLDOWN_CYCLES clocks.
  - Then -> LISTEN with `hear_en` = 1 if `enable` = 1; otherwise -> IDLE.
  - `enable` falling here does not abort; the cooldown completes.
- `enable` = 0 in LISTEN or CONFIRM -> IDLE next edge.
  - In CONFIRM this also gives `aborted` = 1 for one cycle.
- `enable` = 0 in EXECUTE -> IDLE next edge: motors 0, `aborted` = 1, no `cmd_done`, `cmd_count` unchanged, `active_cmd` retained.
- Simultaneous events:
  - `enable` falling on the final EXECUTE clock -> abort wins (no `cmd_done`).
  - Reset overrides everything.
- `command` is ignored outside LISTEN and CONFIRM.
- Motor outputs are mutually exclusive at all times.
- `cmd_count` wraps 255 -> 0 on the next completed run; no saturation.

Test Plan:
(CONFIRM_CYCLES = 4, RUN_CYCLES = 8, COOLDOWN_CYCLES = 3 unless stated.)
1. Reset, `enable` = 1, `command` = 001 held -> accepted on the 4th sample. `motor_fwd` = 1 for exactly 8 clocks; `cmd_done` pulses on the edge `motor_fwd` falls; `hear_en` low for 11 clocks, then high; `cmd_count` = 1; `active_cmd` = 001.
2. `command` = 010 for 3 clocks, then 000 -> no motor output, state returns to LISTEN, `hear_en` stays 1, `cmd_count` = 0. Repeat with 010 -> 100 after 2 clocks, then 100 held -> `motor_turn` after 4 samples of 100.
3. `command` = 011 and 111 held for 20 clocks -> no motor output, no CONFIRM entry.
4. `enable` dropped on the 5th EXECUTE clock -> motors 0 on the next edge, `aborted` pulse, no `cmd_done`, state IDLE. Re-raising `enable` -> LISTEN.
5. Reset asserted asynchronously mid-EXECUTE (between edges) -> all outputs 0 immediately; after release, state is IDLE and `cmd_count` = 0.
6. 256 completed runs of alternating 001/100 -> `cmd_count` goes 255 -> 0. Motor outputs are never simultaneously high (assertion checked every cycle).

Source files
------------

// File: rtl/tone_cmd_sequencer.sv
// tone_cmd_sequencer: confirms HearFreq tone commands and runs timed motor actions with cooldown
module tone_cmd_sequencer #(
    parameter int CONFIRM_CYCLES  = 10_000_000,
    parameter int RUN_CYCLES      = 100_000_000,
    parameter int COOLDOWN_CYCLES = 20_000_000,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] command,
    output logic       hear_en,
    output logic       motor_fwd,
    output logic       motor_rev,
    output logic       motor_turn,
    output logic [2:0] active_cmd,
    output logic       busy,
    output logic       cmd_done,
    output logic       aborted,
    output logic [7:0] cmd_count
);
    typedef enum logic [2:0] {IDLE, LISTEN, CONFIRM, EXECUTE, COOLDOWN} state_t;

    localparam logic [CNT_W-1:0] CONF_N = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0] RUN_N  = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] COOL_N = CNT_W'(COOLDOWN_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    logic [2:0]       cand_q, cand_d;
    logic [2:0]       act_q, act_d;
    logic [2:0]       motor_q, motor_d;
    logic             hear_q, hear_d, busy_q, busy_d;
    logic             done_q, done_d, abort_q, abort_d;
    logic [7:0]       count_q, count_d;
    logic             cmd_valid;

    assign timer_inc = timer_q + 1'b1;
    assign cmd_valid = (command == 3'b001) || (command == 3'b010) || (command == 3'b100);

    // state, timer, candidate and registered outputs; reset clears everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            cand_q  <= '0;
            act_q   <= '0;
            motor_q <= '0;
            hear_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cand_q  <= cand_d;
            act_q   <= act_d;
            motor_q <= motor_d;
            hear_q  <= hear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            count_q <= count_d;
        end
    end

    // next state: timer counts samples/clocks already spent in the current phase
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cand_d  = cand_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (enable) state_d = LISTEN;
            end
            LISTEN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cmd_valid) begin
                    cand_d  = command;
                    state_d = (CONF_N == 1) ? EXECUTE : CONFIRM;
                    timer_d = (CONF_N == 1) ? '0 : CNT_W'(1);
                end
            end
            CONFIRM: begin
                if (!enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (command != cand_q) begin
                    state_d = LISTEN;
                    timer_d = '0;
                end else if (timer_inc == CONF_N) begin
                    state_d = EXECUTE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            EXECUTE: begin
                if (!enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_inc == RUN_N) begin
                    state_d = COOLDOWN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            COOLDOWN: begin
                if (timer_inc == COOL_N) begin
                    state_d = enable ? LISTEN : IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // output next values derived from the transition so they change on the same edge as state
    always_comb begin
        act_d   = (state_d == EXECUTE && state_q != EXECUTE) ? cand_d : act_q;
        motor_d = (state_d == EXECUTE) ? act_d : 3'b000;
        hear_d  = (state_d == LISTEN) || (state_d == CONFIRM);
        busy_d  = (state_d == EXECUTE) || (state_d == COOLDOWN);
        done_d  = (state_q == EXECUTE) && (state_d == COOLDOWN);
        abort_d = ((state_q == CONFIRM) || (state_q == EXECUTE)) && (state_d == IDLE);
        count_d = count_q + 8'(done_d);
    end

    assign hear_en    = hear_q;
    assign motor_fwd  = motor_q[0];
    assign motor_rev  = motor_q[1];
    assign motor_turn = motor_q[2];
    assign active_cmd = act_q;
    assign busy       = busy_q;
    assign cmd_done   = done_q;
    assign aborted    = abort_q;
    assign cmd_count  = count_q;
endmodule

// File: tb/tb_tone_cmd_sequencer.sv
// tb_tone_cmd_sequencer: directed scenarios for tone_cmd_sequencer with CONFIRM=4, RUN=8, COOLDOWN=3
module tb_tone_cmd_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] command;
    logic       hear_en, motor_fwd, motor_rev, motor_turn;
    logic [2:0] active_cmd;
    logic       busy, cmd_done, aborted;
    logic [7:0] cmd_count;
    int         errors = 0;
    int         checks = 0;

    tone_cmd_sequencer #(
        .CONFIRM_CYCLES(4),
        .RUN_CYCLES(8),
        .COOLDOWN_CYCLES(3),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .command(command),
        .hear_en(hear_en),
        .motor_fwd(motor_fwd),
        .motor_rev(motor_rev),
        .motor_turn(motor_turn),
        .active_cmd(active_cmd),
        .busy(busy),
        .cmd_done(cmd_done),
        .aborted(aborted),
        .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    // motor outputs must never overlap
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ($countones({motor_turn, motor_rev, motor_fwd}) > 1) begin
                errors++;
                $display("FAIL motor_mutex motors=%b required at most one high", {motor_turn, motor_rev, motor_fwd});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called right after the EXECUTE entry edge; checks the rest of the run and the cooldown
    task automatic finish_run(input logic [2:0] mot, input logic [7:0] cnt);
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if ({motor_turn, motor_rev, motor_fwd} !== mot || cmd_done !== 1'b0 || hear_en !== 1'b0) begin
                errors++;
                $display("FAIL run_hold k=%0d motors=%b done=%b hear=%b required motors=%b done=0 hear=0",
                         k, {motor_turn, motor_rev, motor_fwd}, cmd_done, hear_en, mot);
            end
        end
        tick();
        checks++;
        if ({motor_turn, motor_rev, motor_fwd} !== 3'b000 || cmd_done !== 1'b1 || cmd_count !== cnt || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_end motors=%b done=%b count=%0d busy=%b required motors=000 done=1 count=%0d busy=1",
                     {motor_turn, motor_rev, motor_fwd}, cmd_done, cmd_count, busy, cnt);
        end
        tick();
        checks++;
        if (cmd_done !== 1'b0 || hear_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cool_1 done=%b hear=%b busy=%b required 0 0 1", cmd_done, hear_en, busy);
        end
        tick();
        checks++;
        if (hear_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cool_2 hear=%b busy=%b required 0 1", hear_en, busy);
        end
        tick();
        checks++;
        if (hear_en !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cool_exit hear=%b busy=%b required 1 0", hear_en, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        command = 3'b000;
        repeat (2) tick();
        checks++;
        if ({hear_en, motor_fwd, motor_rev, motor_turn, active_cmd, busy, cmd_done, aborted, cmd_count} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required 0",
                     {hear_en, motor_fwd, motor_rev, motor_turn, active_cmd, busy, cmd_done, aborted, cmd_count});
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (hear_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_hear got=%b required 0", hear_en);
        end
    endtask

    task automatic test_single_run();
        enable = 1'b1;
        command = 3'b001;
        tick();
        checks++;
        if (hear_en !== 1'b1) begin
            errors++;
            $display("FAIL listen_hear got=%b required 1", hear_en);
        end
        repeat (3) tick();
        checks++;
        if ({motor_turn, motor_rev, motor_fwd} !== 3'b000 || hear_en !== 1'b1) begin
            errors++;
            $display("FAIL confirm_3rd motors=%b hear=%b required 000 1", {motor_turn, motor_rev, motor_fwd}, hear_en);
        end
        tick();
        checks++;
        if ({motor_turn, motor_rev, motor_fwd} !== 3'b001 || active_cmd !== 3'b001 || hear_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_fwd motors=%b act=%b hear=%b busy=%b required 001 001 0 1",
                     {motor_turn, motor_rev, motor_fwd}, active_cmd, hear_en, busy);
        end
        command = 3'b000;
        finish_run(3'b001, 8'd1);
        checks++;
        if (active_cmd !== 3'b001) begin
            errors++;
            $display("FAIL active_hold got=%b required 001", active_cmd);
        end
    endtask

    task automatic test_confirm_reject();
        command = 3'b010;
        repeat (3) tick();
        command = 3'b000;
        tick();
        repeat (2) begin
            tick();
            checks++;
            if ({motor_turn, motor_rev, motor_fwd} !== 3'b000 || hear_en !== 1'b1 || busy !== 1'b0 || cmd_count !== 8'd1) begin
                errors++;
                $display("FAIL reject_short motors=%b hear=%b busy=%b count=%0d required 000 1 0 1",
                         {motor_turn, motor_rev, motor_fwd}, hear_en, busy, cmd_count);
            end
        end
        command = 3'b010;
        repeat (2) tick();
        command = 3'b100;
        repeat (4) tick();
        checks++;
        if ({motor_turn, motor_rev, motor_fwd} !== 3'b000) begin
            errors++;
            $display("FAIL switch_early motors=%b required 000", {motor_turn, motor_rev, motor_fwd});
        end
        tick();
        checks++;
        if ({motor_turn, motor_rev, motor_fwd} !== 3'b100 || active_cmd !== 3'b100) begin
            errors++;
            $display("FAIL switch_accept motors=%b act=%b required 100 100", {motor_turn, motor_rev, motor_fwd}, active_cmd);
        end
        command = 3'b000;
        finish_run(3'b100, 8'd2);
    endtask

    task automatic test_invalid();
        logic [2:0] bad [2] = '{3'b011, 3'b111};
        for (int b = 0; b < 2; b++) begin
            command = bad[b];
            for (int k = 0; k < 20; k++) begin
                tick();
                checks++;
                if ({motor_turn, motor_rev, motor_fwd} !== 3'b000 || busy !== 1'b0 || hear_en !== 1'b1) begin
                    errors++;
                    $display("FAIL invalid_%b k=%0d motors=%b busy=%b hear=%b required 000 0 1",
                             bad[b], k, {motor_turn, motor_rev, motor_fwd}, busy, hear_en);
                end
            end
        end
        command = 3'b000;
        checks++;
        if (active_cmd !== 3'b100 || cmd_count !== 8'd2) begin
            errors++;
            $display("FAIL invalid_state act=%b count=%0d required 100 2", active_cmd, cmd_count);
        end
    endtask

    task automatic test_abort();
        command = 3'b001;
        repeat (4) tick();
        command = 3'b000;
        repeat (4) tick();
        checks++;
        if ({motor_turn, motor_rev, motor_fwd} !== 3'b001) begin
            errors++;
            $display("FAIL abort_pre motors=%b required 001", {motor_turn, motor_rev, motor_fwd});
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({motor_turn, motor_rev, motor_fwd} !== 3'b000 || aborted !== 1'b1 || cmd_done !== 1'b0 ||
            cmd_count !== 8'd2 || active_cmd !== 3'b001 || hear_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_exec motors=%b abort=%b done=%b count=%0d act=%b hear=%b busy=%b required 000 1 0 2 001 0 0",
                     {motor_turn, motor_rev, motor_fwd}, aborted, cmd_done, cmd_count, active_cmd, hear_en, busy);
        end
        tick();
        checks++;
        if (aborted !== 1'b0 || hear_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse abort=%b hear=%b required 0 0", aborted, hear_en);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (hear_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_relisten hear=%b required 1", hear_en);
        end
    endtask

    task automatic test_abort_boundaries();
        command = 3'b100;
        repeat (4) tick();
        command = 3'b000;
        repeat (7) tick();
        enable = 1'b0;
        tick();
        checks++;
        if ({motor_turn, motor_rev, motor_fwd} !== 3'b000 || aborted !== 1'b1 || cmd_done !== 1'b0 || cmd_count !== 8'd2) begin
            errors++;
            $display("FAIL abort_final motors=%b abort=%b done=%b count=%0d required 000 1 0 2",
                     {motor_turn, motor_rev, motor_fwd}, aborted, cmd_done, cmd_count);
        end
        enable = 1'b1;
        tick();
        command = 3'b010;
        repeat (2) tick();
        enable = 1'b0;
        tick();
        checks++;
        if (aborted !== 1'b1 || hear_en !== 1'b0 || {motor_turn, motor_rev, motor_fwd} !== 3'b000) begin
            errors++;
            $display("FAIL abort_confirm abort=%b hear=%b motors=%b required 1 0 000",
                     aborted, hear_en, {motor_turn, motor_rev, motor_fwd});
        end
        command = 3'b000;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        command = 3'b001;
        repeat (4) tick();
        command = 3'b000;
        tick();
        #3;
        reset = 1'b1;
        enable = 1'b0;
        #1;
        checks++;
        if ({hear_en, motor_fwd, motor_rev, motor_turn, active_cmd, busy, cmd_done, aborted, cmd_count} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset got=%h required 0",
                     {hear_en, motor_fwd, motor_rev, motor_turn, active_cmd, busy, cmd_done, aborted, cmd_count});
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (hear_en !== 1'b0 || cmd_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset hear=%b count=%0d busy=%b required 0 0 0", hear_en, cmd_count, busy);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (hear_en !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_listen hear=%b required 1", hear_en);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            logic [2:0] c;
            int n;
            c = i[0] ? 3'b100 : 3'b001;
            command = c;
            n = 0;
            while ({motor_turn, motor_rev, motor_fwd} === 3'b000 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if ({motor_turn, motor_rev, motor_fwd} !== c) begin
                errors++;
                $display("FAIL wrap_start run=%0d motors=%b required %b", i, {motor_turn, motor_rev, motor_fwd}, c);
            end
            command = 3'b000;
            finish_run(c, 8'(i + 1));
        end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_confirm_reject();
        test_invalid();
        test_abort();
        test_abort_boundaries();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
